// File: rtl/harvard_bridge_pkg.sv
// Shared types and constants for the Harvard-to-single-bus memory bridge.
package harvard_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } bridge_state_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  BYTEEN_ALL      = 4'hF;

  // Word address used both on the bus and as a buffer tag.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/tagged_word_buffer.sv
// One-word buffer with a valid bit and an address tag; reports a hit for a lookup address.
module tagged_word_buffer #(
  parameter logic [31:0] RESET_TAG   = 32'h0000_0000,
  parameter bit          MATCH_INVAL = 1'b0   // 1: inval only applies when the tag equals inval_addr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inval,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [31:0] inval_addr,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] data_out
);

  logic        valid_q;
  logic [31:0] tag_q;
  logic [31:0] data_q;
  logic        inval_now;

  assign inval_now = inval && (!MATCH_INVAL || (tag_q == inval_addr));

  // Capture a fetched word, or drop validity when the word may have gone stale.
  always_ff @(posedge clk) begin
    // NOTE: state is written with <= so every register samples pre-edge values, whatever the statement order.
    if (reset) begin
      // NOTE: the data word is reset too, because the CPU sees 0 on its read ports straight after reset.
      valid_q <= 1'b0;
      tag_q   <= RESET_TAG;   // tag value is irrelevant while invalid
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= addr_in;
      data_q  <= data_in;
    end else if (inval_now) begin
      valid_q <= 1'b0;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign data_out = data_q;

endmodule

// File: rtl/harvard_mem_bridge.sv
// Serialises CPU instruction fetches, data reads and data writes onto one
// waitrequest-style bus, and gates the CPU clock enable until its words are ready.
module harvard_mem_bridge
  import harvard_bridge_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  bridge_state_t state_q, state_d, op;
  logic          wr_done_q;
  logic [31:0]   iaddr, daddr;
  logic          ibuf_hit, dbuf_hit;
  logic          ibuf_load, dbuf_load, wr_accept, step;

  assign iaddr = word_addr(cpu_instr_address);
  assign daddr = word_addr(cpu_data_address);

  // The instruction buffer also drops its word when the CPU stores to that address.
  tagged_word_buffer #(.RESET_TAG(RESET_VECTOR), .MATCH_INVAL(1'b1)) u_ibuf (
    .clk        (clk),
    .reset      (reset),
    .load       (ibuf_load),
    .inval      (wr_accept),
    .addr_in    (iaddr),
    .data_in    (mem_readdata),
    .inval_addr (daddr),
    .lookup_addr(iaddr),
    .hit        (ibuf_hit),
    .data_out   (cpu_instr_readdata)
  );

  // Any accepted store invalidates the data buffer.
  tagged_word_buffer #(.RESET_TAG(32'h0), .MATCH_INVAL(1'b0)) u_dbuf (
    .clk        (clk),
    .reset      (reset),
    .load       (dbuf_load),
    .inval      (wr_accept),
    .addr_in    (daddr),
    .data_in    (mem_readdata),
    .inval_addr (daddr),
    .lookup_addr(daddr),
    .hit        (dbuf_hit),
    .data_out   (cpu_data_readdata)
  );

  // Pick this cycle's work: a fresh priority decision when idle, else keep the stalled transaction.
  always_comb begin
    op = state_q;
    if (state_q == IDLE) begin
      if (!ibuf_hit)                          op = IFETCH;
      else if (cpu_data_write && !wr_done_q)  op = DWRITE;
      else if (cpu_data_read && !dbuf_hit)    op = DREAD;
      else                                    op = IDLE;
    end
  end

  // Bus command, buffer updates, CPU step and next state; the command issues in the deciding cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    state_d        = state_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = iaddr;
    cpu_clk_enable = 1'b0;
    ibuf_load      = 1'b0;
    dbuf_load      = 1'b0;
    wr_accept      = 1'b0;
    step           = 1'b0;
    if (reset) begin
      // Let the CPU take its own synchronous reset on this edge; the bus command drops now.
      cpu_clk_enable = 1'b1;
      state_d        = IDLE;
    end else begin
      unique case (op)
        IFETCH: begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            ibuf_load = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = IFETCH;
          end
        end
        DREAD: begin
          mem_read    = 1'b1;
          mem_address = daddr;
          if (!mem_waitrequest) begin
            dbuf_load = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = DREAD;
          end
        end
        DWRITE: begin
          mem_write   = 1'b1;
          mem_address = daddr;
          if (!mem_waitrequest) begin
            wr_accept = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = DWRITE;
          end
        end
        default: begin
          cpu_clk_enable = 1'b1;
          step           = 1'b1;
          state_d        = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Remember that the current store was accepted until the CPU steps past it.
  always_ff @(posedge clk) begin
    if (reset)          wr_done_q <= 1'b0;
    else if (wr_accept) wr_done_q <= 1'b1;
    else if (step)      wr_done_q <= 1'b0;
  end

  assign mem_writedata  = cpu_data_writedata;
  assign mem_byteenable = BYTEEN_ALL;

endmodule

// File: tb/tb_harvard_mem_bridge.sv
// Bench acting as both the CPU and the memory slave for harvard_mem_bridge.
module tb_harvard_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_clk_enable;
  logic [31:0] cpu_instr_address, cpu_instr_readdata;
  logic [31:0] cpu_data_address, cpu_data_writedata, cpu_data_readdata;
  logic        cpu_data_read, cpu_data_write;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [3:0]  mem_byteenable;

  harvard_mem_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_clk_enable    (cpu_clk_enable),
    .cpu_instr_address (cpu_instr_address),
    .cpu_instr_readdata(cpu_instr_readdata),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_readdata      (mem_readdata),
    .mem_waitrequest   (mem_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory seen by the slave (changed only by bus writes) and the CPU's view of memory.
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] gold_mem  [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2402_0005 : (a ^ 32'hA5A5_0F0F);
  endfunction
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold_mem.exists(a) ? gold_mem[a] : init_word(a);
  endfunction

  // Bus monitor / slave state.
  int          n_reads = 0, n_writes = 0, n_rd_cycles = 0, n_wr_cycles = 0;
  int          stall_left = 0;
  bit          rand_wait = 1'b0;
  logic        obs_step, obs_rd, obs_wr;
  logic [31:0] obs_instr, obs_data, last_read_addr;
  logic        prev_wait_cmd = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  // One clock: answer the bus, sample outputs before the edge, then move to the next falling edge.
  task automatic clk_cycle();
    #1;
    if (mem_read || mem_write) begin
      if (rand_wait)           mem_waitrequest = ($urandom_range(0, 2) == 0);
      else if (stall_left > 0) begin mem_waitrequest = 1'b1; stall_left--; end
      else                     mem_waitrequest = 1'b0;
    end else begin
      mem_waitrequest = 1'b0;
    end
    mem_readdata = mem_read ? slave_rd(mem_address) : $urandom();
    #1;
    obs_step  = cpu_clk_enable;
    obs_rd    = mem_read;
    obs_wr    = mem_write;
    obs_instr = cpu_instr_readdata;
    obs_data  = cpu_data_readdata;
    if (mem_read || mem_write) begin
      check("bus_addr_aligned", {30'd0, mem_address[1:0]}, 32'd0);
      check("clk_en_low_on_bus", {31'd0, cpu_clk_enable}, 32'd0);
      check("byteenable", {28'd0, mem_byteenable}, 32'hF);
    end
    if (prev_wait_cmd && !reset) begin
      check("hold_cmd", {30'd0, mem_read, mem_write}, {30'd0, prev_rd, prev_wr});
      check("hold_addr", mem_address, prev_addr);
      if (prev_wr) check("hold_wdata", mem_writedata, prev_wdata);
    end
    if (mem_read)  n_rd_cycles++;
    if (mem_write) n_wr_cycles++;
    if (mem_read && !mem_waitrequest) begin
      n_reads++;
      last_read_addr = mem_address;
    end
    if (mem_write && !mem_waitrequest) begin
      n_writes++;
      slave_mem[mem_address] = mem_writedata;
    end
    prev_wait_cmd = (mem_read || mem_write) && mem_waitrequest;
    prev_rd    = mem_read;
    prev_wr    = mem_write;
    prev_addr  = mem_address;
    prev_wdata = mem_writedata;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] iaddr;
    logic        rd;
    logic        wr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    int          exp_cycles;   // -1: not checked
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ia, input logic r, input logic w,
                              input logic [31:0] da, input logic [31:0] wd,
                              input int c, input int nr, input int nw);
    vec_t v;
    v.iaddr = ia; v.rd = r; v.wr = w; v.daddr = da; v.wdata = wd;
    v.exp_cycles = c; v.exp_reads = nr; v.exp_writes = nw;
    return v;
  endfunction

  // Present one CPU state and hold it until the bridge lets the CPU step.
  task automatic run_state(input vec_t v);
    int  cyc, r0, w0;
    bit  done;
    cpu_instr_address  = v.iaddr;
    cpu_data_read      = v.rd;
    cpu_data_write     = v.wr;
    cpu_data_address   = v.daddr;
    cpu_data_writedata = v.wdata;
    r0 = n_reads; w0 = n_writes; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      clk_cycle();
      cyc++;
      done = obs_step;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_timeout: got no step after %0d cycles, expected a step", cyc);
    end
    if (v.wr) gold_mem[v.daddr] = v.wdata;
    check("writes_per_state", 32'(n_writes - w0), v.wr ? 32'd1 : 32'd0);
    check("instr_word", obs_instr, gold_rd(v.iaddr));
    if (v.rd) check("data_word", obs_data, gold_rd(v.daddr));
    if (v.exp_cycles >= 0) begin
      check("state_cycles", 32'(cyc), 32'(v.exp_cycles));
      check("bus_reads", 32'(n_reads - r0), 32'(v.exp_reads));
      check("bus_writes", 32'(n_writes - w0), 32'(v.exp_writes));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs [12];
  vec_t v;
  int   c0, w_before;
  logic [31:0] ipool [6];
  logic [31:0] dpool [5];

  initial begin
    // Zero-wait-bus CPU states: {instr, rd, wr, daddr, wdata, cycles, reads, writes}.
    vecs[0]  = mk(32'hBFC00000, 0, 0, 32'h0,        32'h0,        2, 1, 0);
    vecs[1]  = mk(32'hBFC00000, 0, 0, 32'h0,        32'h0,        1, 0, 0);
    vecs[2]  = mk(32'hBFC00004, 1, 0, 32'h00001000, 32'h0,        3, 2, 0);
    vecs[3]  = mk(32'hBFC00004, 1, 0, 32'h00001000, 32'h0,        1, 0, 0);
    vecs[4]  = mk(32'hBFC00008, 0, 1, 32'h00000010, 32'hDEADBEEF, 3, 1, 1);
    vecs[5]  = mk(32'hBFC00008, 1, 0, 32'h00000010, 32'h0,        2, 1, 0);
    vecs[6]  = mk(32'h00000010, 0, 0, 32'h0,        32'h0,        2, 1, 0);
    vecs[7]  = mk(32'h00000010, 0, 1, 32'h00000010, 32'h11111111, 3, 1, 1);
    vecs[8]  = mk(32'h00000010, 1, 1, 32'h00001000, 32'h22222222, 3, 1, 1);
    vecs[9]  = mk(32'h00000010, 0, 0, 32'h0,        32'h0,        1, 0, 0);
    vecs[10] = mk(32'hBFC0000C, 1, 0, 32'h00000010, 32'h0,        3, 2, 0);
    vecs[11] = mk(32'hBFC0000C, 0, 1, 32'h00000010, 32'h11111133, 2, 0, 1);

    reset = 1'b1;
    cpu_instr_address = 32'hBFC00000;
    cpu_data_address = '0; cpu_data_read = 1'b0; cpu_data_write = 1'b0;
    cpu_data_writedata = '0; mem_readdata = '0; mem_waitrequest = 1'b0;

    // Reset cycles: CPU enabled so it resets too, no bus command.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      clk_cycle();
      check("reset_clk_en", {31'd0, obs_step}, 32'd1);
      check("reset_bus_cmd", {30'd0, obs_rd, obs_wr}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("post_reset_instr", cpu_instr_readdata, 32'd0);
    check("post_reset_data", cpu_data_readdata, 32'd0);
    check("post_reset_fetch_addr", mem_address, 32'hBFC00000);
    check("post_reset_clk_en", {31'd0, cpu_clk_enable}, 32'd0);

    for (int i = 0; i < 12; i++) run_state(vecs[i]);

    // Load with three waitrequest cycles: the address is held for four cycles.
    c0 = n_rd_cycles;
    stall_left = 3;
    run_state(mk(32'hBFC0000C, 1, 0, 32'h00001040, 32'h0, 5, 1, 0));
    check("lw_read_cycles", 32'(n_rd_cycles - c0), 32'd4);

    // Stalled store issues once; the data buffer must be refetched afterwards.
    c0 = n_wr_cycles;
    stall_left = 2;
    run_state(mk(32'hBFC0000C, 0, 1, 32'h00000020, 32'hDEADBEEF, 4, 0, 1));
    check("sw_write_cycles", 32'(n_wr_cycles - c0), 32'd3);
    run_state(mk(32'hBFC0000C, 1, 0, 32'h00001040, 32'h0, 2, 1, 0));

    // Reset while a store is stalled on the bus.
    w_before = n_writes;
    stall_left = 10;
    cpu_instr_address = 32'hBFC0000C; cpu_data_read = 1'b0; cpu_data_write = 1'b1;
    cpu_data_address = 32'h00000030; cpu_data_writedata = 32'h33333333;
    clk_cycle();
    clk_cycle();
    check("stalled_write_active", {31'd0, obs_wr}, 32'd1);
    reset = 1'b1;
    clk_cycle();
    check("abort_mem_write", {31'd0, obs_wr}, 32'd0);
    check("abort_clk_en", {31'd0, obs_step}, 32'd1);
    reset = 1'b0;
    stall_left = 0;
    cpu_data_write = 1'b0;
    cpu_instr_address = 32'hBFC00000;
    #1;
    check("abort_instr_cleared", cpu_instr_readdata, 32'd0);
    check("abort_data_cleared", cpu_data_readdata, 32'd0);
    run_state(mk(32'hBFC00000, 0, 0, 32'h0, 32'h0, 2, 1, 0));
    check("abort_refetch_addr", last_read_addr, 32'hBFC00000);
    check("abort_no_write", 32'(n_writes - w_before), 32'd0);
    check("abort_mem_untouched", slave_rd(32'h00000030), init_word(32'h00000030));

    // Random CPU states against random waitrequest.
    ipool = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'h00000100, 32'h00000104, 32'h00000108};
    dpool = '{32'h00000100, 32'h00000104, 32'h00000108, 32'h0000010C, 32'hBFC00004};
    rand_wait = 1'b1;
    v = mk(32'hBFC00000, 0, 0, 32'h0, 32'h0, -1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) != 0) begin
        int op;
        op = $urandom_range(0, 3);
        v = mk(ipool[$urandom_range(0, 5)], op[0], op[1], dpool[$urandom_range(0, 4)],
               $urandom(), -1, 0, 0);
      end
      run_state(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
